seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 The block SHALL have parameter SETTLE, default 4: consecutive identical samples required before a digit is captured.
REQ-002 The block SHALL have parameter TIMEOUT, default 1024: idle cycles with no anode asserted before all digits are invalidated.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all logic rises on it.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have ports a, b, c, d, e, f, g, dp, input, 1 each, segment lines, active-low.
REQ-006 The block SHALL have ports an1, an2, an3, an4, input, 1 each, digit anodes, active-low; an1 selects digit 0.
REQ-007 The block SHALL have port digit, output, 16, four captured hex nibbles; [3:0] is digit 0.
REQ-008 The block SHALL have port dp_out, output, 4, captured decimal-point state per digit, active-high.
REQ-009 The block SHALL have port valid, output, 4, per-digit flag: the nibble holds a decoded pattern.
REQ-010 The block SHALL have port frame_done, output, 1, one-cycle pulse when all four digits have been captured since the previous pulse.
REQ-011 The block SHALL have port err_pattern, output, 1, one-cycle pulse on capture of an undecodable non-blank pattern.
REQ-012 The block SHALL have port err_multi, output, 1, one-cycle pulse when two or more anodes are sampled low.

Function
REQ-013 All inputs SHALL be registered once; all decisions use the registered sample (1-cycle input latency).
REQ-014 The FSM SHALL have states IDLE (no anode low), SETTLE (one anode low, counting), HOLD (captured, waiting for a change).
REQ-015 IDLE -> SETTLE SHALL occur when exactly one anode is low; the settle counter loads 1.
REQ-016 In SETTLE, an unchanged {anodes, segments, dp} SHALL increment the counter; any change SHALL reload it to 1 and stay in SETTLE (or go to IDLE if no anode is low).
REQ-017 Upon the counter reaching SETTLE, the block SHALL capture on that edge and go to HOLD; capture latency SHALL be SETTLE+1 cycles after the input settles.
REQ-018 In HOLD, any change SHALL go to SETTLE (one anode low) or IDLE (none); a stable input SHALL cause no recapture.
REQ-019 Decode SHALL use the standard hex font: 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc, 8 all, 9 abcdfg, A abcefg, b cdefg, C adef, d bcdeg, E adefg, F aefg.
REQ-020 Capture of a valid pattern SHALL write the nibble and dp, and set valid[i].
REQ-021 Capture of all segments off SHALL clear valid[i], leave the nibble unchanged, write dp, and raise no error.
REQ-022 Capture of any other pattern SHALL clear valid[i], leave the nibble unchanged, and pulse err_pattern.
REQ-023 Two or more anodes low SHALL pulse err_multi on each sampled cycle, force IDLE, and capture nothing.
REQ-024 Each capture, including blank or error captures, SHALL set seen[i]; when seen is 4'b1111, frame_done SHALL pulse on the same edge and seen SHALL clear.
REQ-025 The idle counter SHALL count cycles in IDLE and saturate at TIMEOUT; on reaching TIMEOUT, valid and seen SHALL clear; any anode low SHALL clear the idle counter.
REQ-026 Recapture of the same digit before the frame completes SHALL overwrite it and SHALL NOT pulse frame_done.

Reset
REQ-027 Reset SHALL give: state IDLE, digit 16'h0000, dp_out 4'h0, valid 4'h0, seen 4'h0, counters 0, frame_done/err_pattern/err_multi 0, input registers all-ones (inactive).
REQ-028 Reset asserted mid-SETTLE SHALL discard the partial count; no capture SHALL occur on the reset edge.

Structure
REQ-029 Package seg_scan_pkg SHALL hold the FSM state encoding, the 16 font constants, and the BLANK constant.
REQ-030 The combinational decode SHALL be the sub-module seg7_to_hex (in: 7-bit segments; out: nibble, ok, blank).

Verification
REQ-031 Scan "1234" (an1..an4 = 1,2,3,4), 8 cycles per digit -> digit=16'h4321, valid=4'hF, one frame_done after digit 3's capture.
REQ-032 Hold an2 low with pattern abcdg, toggling segment c every 3 cycles (SETTLE=4) -> no capture, valid[1] unchanged.
REQ-033 Hold an3 low with pattern a+g only for 8 cycles -> err_pattern one pulse, valid[2]=0, digit[11:8] unchanged.
REQ-034 Hold an1 and an4 low together for 5 cycles -> err_multi high for 5 cycles, no capture, state IDLE.
REQ-035 After a full frame, all anodes high for 1024 cycles -> valid=4'h0, digit unchanged.
REQ-036 Assert reset for 1 cycle during an2's SETTLE count -> all outputs at reset values, no capture for digit 1.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared FSM encoding and seven-segment font for the scan decoder
// Segment vectors are active-high, ordered {a,b,c,d,e,f,g} from bit 6 down to bit 0.
package seg_scan_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_HOLD   = 2'd2
   } state_t;

   localparam logic [6:0] BLANK = 7'h00;

   localparam logic [6:0] FONT [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79,
      7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F,
      7'h4E, 7'h3D, 7'h4F, 7'h47
   };

endpackage

// File: rtl/seg7_to_hex.sv
// rtl/seg7_to_hex.sv - combinational seven-segment to hex nibble decode
// ok flags a font match; blank flags all segments off.
module seg7_to_hex
   import seg_scan_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       ok,
   output logic       blank
);

   always_comb begin
      nibble = 4'h0;
      ok     = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (seg == FONT[i]) begin
            nibble = 4'(i);
            ok     = 1'b1;
         end
      end
   end

   assign blank = (seg == BLANK);

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - recovers four hex digits from a multiplexed seven-segment scan
// Inputs are registered once; capture happens after SETTLE identical samples with one anode low.
module seg_scan_decoder
   import seg_scan_pkg::*;
#(
   parameter int SETTLE  = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        a,
   input  logic        b,
   input  logic        c,
   input  logic        d,
   input  logic        e,
   input  logic        f,
   input  logic        g,
   input  logic        dp,
   input  logic        an1,
   input  logic        an2,
   input  logic        an3,
   input  logic        an4,
   output logic [15:0] digit,
   output logic [3:0]  dp_out,
   output logic [3:0]  valid,
   output logic        frame_done,
   output logic        err_pattern,
   output logic        err_multi
);

   localparam int SW = $clog2(SETTLE + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t        state_q, state_d;
   logic [11:0]   samp_q, samp_d;
   logic [11:0]   last_q, last_d;
   logic [SW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] idle_q, idle_d;
   logic [15:0]   digit_q, digit_d;
   logic [3:0]    dp_q, dp_d;
   logic [3:0]    valid_q, valid_d;
   logic [3:0]    seen_q, seen_d;
   logic          frame_q, frame_d;
   logic          errp_q, errp_d;
   logic          errm_q, errm_d;

   logic [3:0] an_low;
   logic [6:0] seg_on;
   logic       dp_on;
   logic       one_low, none_low, multi_low, changed, capture;
   logic [1:0] sel;
   logic [3:0] nibble;
   logic       ok, blank;

   // Raw active-low sample: {an4..an1, a..g, dp}
   assign samp_d    = {an4, an3, an2, an1, a, b, c, d, e, f, g, dp};
   assign last_d    = samp_q;
   assign an_low    = ~samp_q[11:8];
   assign seg_on    = ~samp_q[7:1];
   assign dp_on     = ~samp_q[0];
   assign one_low   = $onehot(an_low);
   assign none_low  = (an_low == 4'h0);
   assign multi_low = !one_low && !none_low;
   assign changed   = (samp_q != last_q);

   always_comb begin
      sel = 2'd0;
      case (an_low)
         4'b0010: sel = 2'd1;
         4'b0100: sel = 2'd2;
         4'b1000: sel = 2'd3;
         default: sel = 2'd0;
      endcase
   end

   seg7_to_hex u_dec (
      .seg    (seg_on),
      .nibble (nibble),
      .ok     (ok),
      .blank  (blank)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idle_d  = idle_q;
      digit_d = digit_q;
      dp_d    = dp_q;
      valid_d = valid_q;
      seen_d  = seen_q;
      frame_d = 1'b0;
      errp_d  = 1'b0;
      errm_d  = 1'b0;
      capture = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (one_low) begin
               state_d = S_SETTLE;
               cnt_d   = SW'(1);
            end
         end
         S_SETTLE: begin
            if (changed) begin
               if (one_low) begin
                  cnt_d = SW'(1);
               end else begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + SW'(1);
            end
         end
         S_HOLD: begin
            if (changed) begin
               state_d = one_low ? S_SETTLE : S_IDLE;
               cnt_d   = one_low ? SW'(1) : '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      if (state_d == S_SETTLE && cnt_d == SW'(SETTLE)) begin
         capture = 1'b1;
         state_d = S_HOLD;
         cnt_d   = '0;
      end

      // Ambiguous anode selection overrides everything, including a pending capture
      if (multi_low) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         errm_d  = 1'b1;
         capture = 1'b0;
      end

      if (capture) begin
         if (ok) begin
            digit_d[{sel, 2'b00} +: 4] = nibble;
            dp_d[sel]                  = dp_on;
            valid_d[sel]               = 1'b1;
         end else begin
            valid_d[sel] = 1'b0;
            if (blank) begin
               dp_d[sel] = dp_on;
            end else begin
               errp_d = 1'b1;
            end
         end
         seen_d[sel] = 1'b1;
         if (seen_d == 4'hF) begin
            frame_d = 1'b1;
            seen_d  = 4'h0;
         end
      end

      if (!none_low) begin
         idle_d = '0;
      end else if (state_q == S_IDLE && idle_q != TW'(TIMEOUT)) begin
         idle_d = idle_q + TW'(1);
      end
      if (idle_d == TW'(TIMEOUT)) begin
         valid_d = 4'h0;
         seen_d  = 4'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         samp_q  <= '1;
         last_q  <= '1;
         cnt_q   <= '0;
         idle_q  <= '0;
         digit_q <= 16'h0000;
         dp_q    <= 4'h0;
         valid_q <= 4'h0;
         seen_q  <= 4'h0;
         frame_q <= 1'b0;
         errp_q  <= 1'b0;
         errm_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         samp_q  <= samp_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         idle_q  <= idle_d;
         digit_q <= digit_d;
         dp_q    <= dp_d;
         valid_q <= valid_d;
         seen_q  <= seen_d;
         frame_q <= frame_d;
         errp_q  <= errp_d;
         errm_q  <= errm_d;
      end
   end

   assign digit       = digit_q;
   assign dp_out      = dp_q;
   assign valid       = valid_q;
   assign frame_done  = frame_q;
   assign err_pattern = errp_q;
   assign err_multi   = errm_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        a, b, c, d, e, f, g, dp;
   logic        an1, an2, an3, an4;
   logic [15:0] digit;
   logic [3:0]  dp_out;
   logic [3:0]  valid;
   logic        frame_done;
   logic        err_pattern;
   logic        err_multi;

   int n_checks = 0;
   int n_fail   = 0;
   int fd_cnt   = 0;
   int ep_cnt   = 0;
   int em_cnt   = 0;

   seg_scan_decoder #(.SETTLE(4), .TIMEOUT(1024)) dut (
      .clk         (clk),
      .reset       (reset),
      .a           (a),
      .b           (b),
      .c           (c),
      .d           (d),
      .e           (e),
      .f           (f),
      .g           (g),
      .dp          (dp),
      .an1         (an1),
      .an2         (an2),
      .an3         (an3),
      .an4         (an4),
      .digit       (digit),
      .dp_out      (dp_out),
      .valid       (valid),
      .frame_done  (frame_done),
      .err_pattern (err_pattern),
      .err_multi   (err_multi)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done)  fd_cnt++;
      if (err_pattern) ep_cnt++;
      if (err_multi)   em_cnt++;
   end

   task automatic drive(input logic [3:0] an_low, input logic [6:0] segs, input logic dpv);
      {an4, an3, an2, an1} = ~an_low;
      {a, b, c, d, e, f, g} = ~segs;
      dp = ~dpv;
   endtask

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic scan_digit(input int idx, input logic [6:0] segs, input logic dpv, input int n);
      logic [3:0] one;
      one = 4'b0001;
      drive(one << idx, segs, dpv);
      hold(n);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      drive(4'h0, 7'h00, 1'b0);
      hold(3);
      n_checks++;
      if (digit !== 16'h0000) begin n_fail++; $display("FAIL reset_digit: got %h expected %h", digit, 16'h0000); end
      n_checks++;
      if (dp_out !== 4'h0) begin n_fail++; $display("FAIL reset_dp_out: got %h expected %h", dp_out, 4'h0); end
      n_checks++;
      if (valid !== 4'h0) begin n_fail++; $display("FAIL reset_valid: got %h expected %h", valid, 4'h0); end
      n_checks++;
      if ({frame_done, err_pattern, err_multi} !== 3'b000) begin
         n_fail++; $display("FAIL reset_pulses: got %b expected %b", {frame_done, err_pattern, err_multi}, 3'b000);
      end
      reset = 1'b0;
      hold(2);
   endtask

   task automatic test_scan_1234;
      int fd0, ep0;
      fd0 = fd_cnt;
      ep0 = ep_cnt;
      scan_digit(0, 7'h30, 1'b1, 4);
      n_checks++;
      if (valid !== 4'h0) begin n_fail++; $display("FAIL scan_latency_early: got %h expected %h", valid, 4'h0); end
      hold(1);
      n_checks++;
      if (valid !== 4'h1 || digit[3:0] !== 4'h1) begin
         n_fail++; $display("FAIL scan_latency_capture: got valid=%h nib=%h expected valid=1 nib=1", valid, digit[3:0]);
      end
      hold(3);
      scan_digit(1, 7'h6D, 1'b0, 8);
      scan_digit(2, 7'h79, 1'b0, 8);
      n_checks++;
      if (fd_cnt - fd0 !== 0) begin n_fail++; $display("FAIL scan_no_early_frame: got %0d expected 0", fd_cnt - fd0); end
      scan_digit(3, 7'h33, 1'b0, 8);
      n_checks++;
      if (digit !== 16'h4321) begin n_fail++; $display("FAIL scan_digit: got %h expected %h", digit, 16'h4321); end
      n_checks++;
      if (valid !== 4'hF) begin n_fail++; $display("FAIL scan_valid: got %h expected %h", valid, 4'hF); end
      n_checks++;
      if (dp_out !== 4'h1) begin n_fail++; $display("FAIL scan_dp: got %h expected %h", dp_out, 4'h1); end
      n_checks++;
      if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL scan_frame_done: got %0d expected 1", fd_cnt - fd0); end
      n_checks++;
      if (ep_cnt - ep0 !== 0) begin n_fail++; $display("FAIL scan_no_err: got %0d expected 0", ep_cnt - ep0); end
      drive(4'h0, 7'h00, 1'b0);
      hold(3);
   endtask

   task automatic test_blank;
      int ep0;
      ep0 = ep_cnt;
      scan_digit(3, 7'h00, 1'b1, 8);
      n_checks++;
      if (valid !== 4'h7 || digit[15:12] !== 4'h4 || dp_out !== 4'h9) begin
         n_fail++; $display("FAIL blank_capture: got valid=%h nib=%h dp=%h expected 7 4 9", valid, digit[15:12], dp_out);
      end
      n_checks++;
      if (ep_cnt - ep0 !== 0) begin n_fail++; $display("FAIL blank_no_err: got %0d expected 0", ep_cnt - ep0); end
      drive(4'h0, 7'h00, 1'b0);
      hold(3);
   endtask

   task automatic test_toggle;
      int ep0;
      logic [6:0] p;
      ep0 = ep_cnt;
      p = 7'h79;
      for (int i = 0; i < 8; i++) begin
         scan_digit(1, p, 1'b0, 3);
         p = p ^ 7'b0010000;
      end
      n_checks++;
      if (valid[1] !== 1'b1 || digit[7:4] !== 4'h2) begin
         n_fail++; $display("FAIL toggle_no_capture: got v1=%b nib=%h expected 1 2", valid[1], digit[7:4]);
      end
      n_checks++;
      if (ep_cnt - ep0 !== 0) begin n_fail++; $display("FAIL toggle_no_err: got %0d expected 0", ep_cnt - ep0); end
      drive(4'h0, 7'h00, 1'b0);
      hold(3);
   endtask

   task automatic test_pattern_err;
      int ep0;
      ep0 = ep_cnt;
      scan_digit(2, 7'h41, 1'b0, 8);
      n_checks++;
      if (ep_cnt - ep0 !== 1) begin n_fail++; $display("FAIL pattern_err_pulse: got %0d expected 1", ep_cnt - ep0); end
      n_checks++;
      if (valid[2] !== 1'b0 || digit[11:8] !== 4'h3) begin
         n_fail++; $display("FAIL pattern_err_state: got v2=%b nib=%h expected 0 3", valid[2], digit[11:8]);
      end
      drive(4'h0, 7'h00, 1'b0);
      hold(3);
   endtask

   task automatic test_multi;
      int em0, ep0;
      em0 = em_cnt;
      ep0 = ep_cnt;
      drive(4'b1001, 7'h30, 1'b0);
      hold(2);
      n_checks++;
      if (err_multi !== 1'b1) begin n_fail++; $display("FAIL multi_level: got %b expected 1", err_multi); end
      hold(3);
      drive(4'h0, 7'h00, 1'b0);
      hold(4);
      n_checks++;
      if (em_cnt - em0 !== 5) begin n_fail++; $display("FAIL multi_count: got %0d expected 5", em_cnt - em0); end
      n_checks++;
      if (valid !== 4'h3 || digit !== 16'h4321 || ep_cnt - ep0 !== 0) begin
         n_fail++; $display("FAIL multi_no_capture: got valid=%h digit=%h expected 3 4321", valid, digit);
      end
   endtask

   task automatic test_timeout;
      scan_digit(0, 7'h30, 1'b0, 8);
      scan_digit(1, 7'h6D, 1'b0, 8);
      scan_digit(2, 7'h79, 1'b0, 8);
      scan_digit(3, 7'h33, 1'b0, 8);
      drive(4'h0, 7'h00, 1'b0);
      hold(1000);
      n_checks++;
      if (valid !== 4'hF) begin n_fail++; $display("FAIL timeout_early: got %h expected %h", valid, 4'hF); end
      hold(30);
      n_checks++;
      if (valid !== 4'h0) begin n_fail++; $display("FAIL timeout_valid: got %h expected %h", valid, 4'h0); end
      n_checks++;
      if (digit !== 16'h4321) begin n_fail++; $display("FAIL timeout_digit: got %h expected %h", digit, 16'h4321); end
   endtask

   task automatic test_back_to_back;
      int fd0;
      fd0 = fd_cnt;
      scan_digit(0, 7'h5B, 1'b0, 8);
      scan_digit(0, 7'h5F, 1'b0, 8);
      n_checks++;
      if (digit[3:0] !== 4'h6) begin n_fail++; $display("FAIL recapture_nibble: got %h expected %h", digit[3:0], 4'h6); end
      scan_digit(1, 7'h70, 1'b0, 8);
      scan_digit(2, 7'h7F, 1'b0, 8);
      n_checks++;
      if (fd_cnt - fd0 !== 0) begin n_fail++; $display("FAIL recapture_no_frame: got %0d expected 0", fd_cnt - fd0); end
      scan_digit(3, 7'h7B, 1'b0, 8);
      n_checks++;
      if (fd_cnt - fd0 !== 1 || digit !== 16'h9876) begin
         n_fail++; $display("FAIL recapture_frame: got fd=%0d digit=%h expected 1 9876", fd_cnt - fd0, digit);
      end
      drive(4'h0, 7'h00, 1'b0);
      hold(3);
   endtask

   task automatic test_reset_mid_settle;
      scan_digit(1, 7'h30, 1'b1, 2);
      reset = 1'b1;
      hold(1);
      reset = 1'b0;
      n_checks++;
      if (digit !== 16'h0000 || dp_out !== 4'h0 || valid !== 4'h0) begin
         n_fail++; $display("FAIL midreset_outputs: got digit=%h dp=%h valid=%h expected 0 0 0", digit, dp_out, valid);
      end
      hold(3);
      drive(4'h0, 7'h00, 1'b0);
      hold(4);
      n_checks++;
      if (valid[1] !== 1'b0 || digit[7:4] !== 4'h0 || dp_out[1] !== 1'b0) begin
         n_fail++; $display("FAIL midreset_no_capture: got v1=%b nib=%h dp1=%b expected 0 0 0", valid[1], digit[7:4], dp_out[1]);
      end
   endtask

   initial begin
      reset = 1'b1;
      drive(4'h0, 7'h00, 1'b0);
      #1;
      test_reset();
      test_scan_1234();
      test_blank();
      test_toggle();
      test_pattern_err();
      test_multi();
      test_timeout();
      test_back_to_back();
      test_reset_mid_settle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
